// File: rtl/chromite_fetch_pc_stage0.sv
// Stage-0 PC generation: holds the fetch PC, the epochs and the pending fence flags.
// Issues tagged fetch requests and fence requests, and applies prediction and flush redirects.
module chromite_fetch_pc_stage0 #(
    parameter int unsigned         XLEN     = 64,
    parameter logic [XLEN-1:0]     RESET_PC = 'h1000
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            flush_valid,
    input  logic [XLEN-1:0] flush_pc,
    input  logic            flush_fence,
    input  logic            flush_sfence,
    input  logic            update_eepoch_en,
    input  logic            update_wepoch_en,
    input  logic            bpu_pred_valid,
    input  logic            bpu_pred_taken,
    input  logic [XLEN-1:0] bpu_pred_target,
    output logic [XLEN-1:0] bpu_req_pc,
    output logic            req_valid,
    input  logic            req_ready,
    output logic [XLEN-1:0] req_pc,
    output logic [1:0]      req_epoch,
    output logic            fence_valid,
    output logic            fence_is_sfence,
    input  logic            fence_ready
);

    localparam int unsigned PCW = XLEN - 2;

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
    logic            delayed_redirect_q, delayed_redirect_d;
    logic            eepoch_q, eepoch_d;
    logic            wepoch_q, wepoch_d;
    logic            fence_q, fence_d;
    logic            sfence_q, sfence_d;

    logic            fence_pending;
    logic            req_fire;
    logic            fence_fire;
    logic [XLEN-1:0] seq_pc;

    // Request/fence valids are gated by reset; a pending delayed redirect wins over the fence.
    always_comb begin
        fence_pending   = fence_q | sfence_q;
        req_valid       = RST_N & (delayed_redirect_q | ~fence_pending);
        fence_valid     = RST_N & fence_pending & ~delayed_redirect_q;
        fence_is_sfence = sfence_q;
        req_pc          = pc_q;
        bpu_req_pc      = pc_q;
        req_epoch       = {eepoch_q, wepoch_q};
        req_fire        = req_valid & req_ready;
        fence_fire      = fence_valid & fence_ready;
        seq_pc          = {pc_q[XLEN-1:2] + PCW'(1), 2'b00};
    end

    // Next-state: epochs toggle independently; flush beats handshake; stalled flush is deferred.
    always_comb begin
        pc_d               = pc_q;
        redirect_pc_d      = redirect_pc_q;
        delayed_redirect_d = delayed_redirect_q;
        eepoch_d           = eepoch_q ^ update_eepoch_en;
        wepoch_d           = wepoch_q ^ update_wepoch_en;
        fence_d            = fence_q;
        sfence_d           = sfence_q;

        if (fence_fire) begin
            fence_d  = 1'b0;
            sfence_d = 1'b0;
        end

        if (flush_valid) begin
            fence_d  = fence_d | flush_fence;
            sfence_d = sfence_d | flush_sfence;
            if (req_valid && !req_ready) begin
                // The stalled request must stay stable, so park the target.
                redirect_pc_d      = flush_pc;
                delayed_redirect_d = 1'b1;
            end else begin
                pc_d               = flush_pc;
                delayed_redirect_d = 1'b0;
            end
        end else if (req_fire) begin
            if (delayed_redirect_q) begin
                pc_d               = redirect_pc_q;
                delayed_redirect_d = 1'b0;
            end else if (bpu_pred_valid && bpu_pred_taken) begin
                pc_d = bpu_pred_target;
            end else begin
                pc_d = seq_pc;
            end
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            pc_q               <= RESET_PC;
            redirect_pc_q      <= '0;
            delayed_redirect_q <= 1'b0;
            eepoch_q           <= 1'b0;
            wepoch_q           <= 1'b0;
            fence_q            <= 1'b0;
            sfence_q           <= 1'b0;
        end else begin
            pc_q               <= pc_d;
            redirect_pc_q      <= redirect_pc_d;
            delayed_redirect_q <= delayed_redirect_d;
            eepoch_q           <= eepoch_d;
            wepoch_q           <= wepoch_d;
            fence_q            <= fence_d;
            sfence_q           <= sfence_d;
        end
    end

endmodule

// File: tb/tb_chromite_fetch_pc_stage0.sv
// Self-checking bench for chromite_fetch_pc_stage0: directed plan plus randomized traffic vs a reference model.
module tb_chromite_fetch_pc_stage0;

    localparam int unsigned XLEN = 64;

    logic            CLK;
    logic            RST_N;
    logic            flush_valid;
    logic [XLEN-1:0] flush_pc;
    logic            flush_fence;
    logic            flush_sfence;
    logic            update_eepoch_en;
    logic            update_wepoch_en;
    logic            bpu_pred_valid;
    logic            bpu_pred_taken;
    logic [XLEN-1:0] bpu_pred_target;
    logic [XLEN-1:0] bpu_req_pc;
    logic            req_valid;
    logic            req_ready;
    logic [XLEN-1:0] req_pc;
    logic [1:0]      req_epoch;
    logic            fence_valid;
    logic            fence_is_sfence;
    logic            fence_ready;

    int n_total = 0;
    int n_bad   = 0;

    // Reference model state
    logic [XLEN-1:0] m_pc, m_rpc;
    logic            m_dred, m_ee, m_we, m_f, m_sf;

    chromite_fetch_pc_stage0 #(.XLEN(XLEN), .RESET_PC(64'h1000)) dut (
        .CLK              (CLK),
        .RST_N            (RST_N),
        .flush_valid      (flush_valid),
        .flush_pc         (flush_pc),
        .flush_fence      (flush_fence),
        .flush_sfence     (flush_sfence),
        .update_eepoch_en (update_eepoch_en),
        .update_wepoch_en (update_wepoch_en),
        .bpu_pred_valid   (bpu_pred_valid),
        .bpu_pred_taken   (bpu_pred_taken),
        .bpu_pred_target  (bpu_pred_target),
        .bpu_req_pc       (bpu_req_pc),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_pc           (req_pc),
        .req_epoch        (req_epoch),
        .fence_valid      (fence_valid),
        .fence_is_sfence  (fence_is_sfence),
        .fence_ready      (fence_ready)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Spec-level next state for one clock edge, from the current inputs.
    task automatic model_edge();
        logic rv, fv;
        if (!RST_N) begin
            m_pc = 64'h1000; m_rpc = '0; m_dred = 0; m_ee = 0; m_we = 0; m_f = 0; m_sf = 0;
            return;
        end
        rv = m_dred || !(m_f || m_sf);
        fv = (m_f || m_sf) && !m_dred;
        if (update_eepoch_en) m_ee = !m_ee;
        if (update_wepoch_en) m_we = !m_we;
        if (fv && fence_ready) begin m_f = 0; m_sf = 0; end
        if (flush_valid) begin
            if (flush_fence)  m_f  = 1;
            if (flush_sfence) m_sf = 1;
            if (rv && !req_ready) begin m_rpc = flush_pc; m_dred = 1; end
            else begin m_pc = flush_pc; m_dred = 0; end
        end else if (rv && req_ready) begin
            if (m_dred) begin m_pc = m_rpc; m_dred = 0; end
            else if (bpu_pred_valid && bpu_pred_taken) m_pc = bpu_pred_target;
            else m_pc = (m_pc & ~64'd3) + 64'd4;
        end
    endtask

    task automatic check_outputs();
        logic pend;
        pend = m_f || m_sf;
        chk("req_valid",   XLEN'(req_valid),   XLEN'(RST_N && (m_dred || !pend)));
        chk("fence_valid", XLEN'(fence_valid), XLEN'(RST_N && pend && !m_dred));
        chk("fence_sfence", XLEN'(fence_is_sfence), XLEN'(m_sf));
        chk("req_pc",      req_pc,     m_pc);
        chk("bpu_req_pc",  bpu_req_pc, m_pc);
        chk("req_epoch",   XLEN'(req_epoch), XLEN'({m_ee, m_we}));
    endtask

    // One clock: model update, edge, then sample at the falling edge.
    task automatic step();
        model_edge();
        @(posedge CLK);
        @(negedge CLK);
        check_outputs();
    endtask

    task automatic idle_inputs();
        flush_valid = 0; flush_pc = '0; flush_fence = 0; flush_sfence = 0;
        update_eepoch_en = 0; update_wepoch_en = 0;
        bpu_pred_valid = 0; bpu_pred_taken = 0; bpu_pred_target = '0;
        req_ready = 1; fence_ready = 0;
    endtask

    initial begin
        RST_N = 0;
        idle_inputs();
        m_pc = '0; m_rpc = '0; m_dred = 0; m_ee = 0; m_we = 0; m_f = 0; m_sf = 0;
        @(negedge CLK);
        step();
        chk("rst_valid", XLEN'(req_valid), '0);
        step();
        RST_N = 1;
        chk("rst_pc", req_pc, 64'h1000);

        // Sequential fetch
        step(); chk("seq1", req_pc, 64'h1004);
        chk("seq_epoch", XLEN'(req_epoch), '0);
        // Taken prediction
        bpu_pred_valid = 1; bpu_pred_taken = 1; bpu_pred_target = 64'h2000;
        step(); chk("pred_taken", req_pc, 64'h2000);
        idle_inputs();
        flush_valid = 1; flush_pc = 64'h1004;
        step(); chk("flush_ready", req_pc, 64'h1004);
        idle_inputs();
        bpu_pred_valid = 1; bpu_pred_taken = 0; bpu_pred_target = 64'h2000;
        step(); chk("pred_nt", req_pc, 64'h1008);
        // Flush against a stalled request
        idle_inputs();
        req_ready = 0; flush_valid = 1; flush_pc = 64'h3002;
        step(); chk("stall_hold", req_pc, 64'h1008);
        chk("stall_valid", XLEN'(req_valid), 64'd1);
        flush_valid = 0;
        step(); chk("stall_hold2", req_pc, 64'h1008);
        req_ready = 1;
        step(); chk("delayed_redir", req_pc, 64'h3002);
        step(); chk("after_redir", req_pc, 64'h3004);
        // Fence + sfence flush
        flush_valid = 1; flush_pc = 64'h4000; flush_fence = 1; flush_sfence = 1;
        step();
        idle_inputs();
        chk("fence_rv", XLEN'(req_valid), '0);
        chk("fence_fv", XLEN'(fence_valid), 64'd1);
        chk("fence_sf", XLEN'(fence_is_sfence), 64'd1);
        for (int i = 0; i < 3; i++) begin
            step(); chk("fence_hold", XLEN'(fence_valid), 64'd1);
        end
        fence_ready = 1;
        step();
        fence_ready = 0;
        chk("fence_done_rv", XLEN'(req_valid), 64'd1);
        chk("fence_done_pc", req_pc, 64'h4000);
        // Epochs
        req_ready = 0; update_eepoch_en = 1; update_wepoch_en = 1;
        step(); chk("epoch11", XLEN'(req_epoch), 64'd3);
        update_wepoch_en = 0;
        step(); chk("epoch01", XLEN'(req_epoch), 64'd1);
        // PC wrap at the top of the address space
        idle_inputs();
        flush_valid = 1; flush_pc = 64'hFFFF_FFFF_FFFF_FFFE;
        step();
        flush_valid = 0;
        step(); chk("wrap", req_pc, 64'h0);
        // Reset mid-stream with a flush present
        RST_N = 0; flush_valid = 1; flush_pc = 64'h5000;
        step();
        chk("mrst_valid", XLEN'(req_valid), '0);
        chk("mrst_fv", XLEN'(fence_valid), '0);
        chk("mrst_pc", req_pc, 64'h1000);
        chk("mrst_epoch", XLEN'(req_epoch), '0);
        RST_N = 1; idle_inputs();
        step(); chk("mrst_rel", req_pc, 64'h1004);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            RST_N            = ($urandom_range(0, 199) != 0);
            flush_valid      = ($urandom_range(0, 9) == 0);
            flush_pc         = {$urandom, $urandom} & ~64'd1;
            if ($urandom_range(0, 15) == 0) flush_pc = 64'hFFFF_FFFF_FFFF_FFF8 | 64'(2 * $urandom_range(0, 3));
            flush_fence      = ($urandom_range(0, 5) == 0);
            flush_sfence     = ($urandom_range(0, 5) == 0);
            update_eepoch_en = ($urandom_range(0, 7) == 0);
            update_wepoch_en = ($urandom_range(0, 7) == 0);
            bpu_pred_valid   = ($urandom_range(0, 2) == 0);
            bpu_pred_taken   = $urandom_range(0, 1) == 1;
            bpu_pred_target  = {$urandom, $urandom} & ~64'd1;
            req_ready        = ($urandom_range(0, 9) < 7);
            fence_ready      = $urandom_range(0, 1) == 1;
            step();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
